// File: rtl/axi4_stream_reader.sv
// rtl/axi4_stream_reader.sv - AXI4 read initiator streaming a contiguous block of beats
module axi4_stream_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int ARID_VAL   = 0,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [LEN_WIDTH-1:0]    num_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic [3:0]              ARCACHE,
    output logic [2:0]              ARPROT,
    output logic                    ARLOCK,
    output logic [3:0]              ARQOS,
    output logic [3:0]              ARREGION,
    output logic [ID_WIDTH-1:0]     ARID,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [ID_WIDTH-1:0]     RID,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic [ID_WIDTH-1:0]     AWID,
    output logic                    AWVALID,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    output logic                    BREADY,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic                    tvalid,
    input  logic                    tready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  arvalid_q, arvalid_d;
    logic                  error_q, error_d;

    logic [ADDR_WIDTH-1:0] seg_addr;
    logic [LEN_WIDTH-1:0]  seg_rem;
    logic [12:0]           bnd_beats;
    logic [8:0]            len_calc;
    logic                  in_data, r_fire, last_beat, load;
    logic                  unused_rid;

    assign unused_rid = ^RID;

    // Next burst starts either at the new request or right after the current burst.
    always_comb begin
        if (state_q == S_IDLE) begin
            seg_addr = start_addr & ~ALIGN_MASK;
            seg_rem  = num_beats;
        end else begin
            seg_addr = araddr_q + (ADDR_WIDTH'(len_q) << SIZE);
            seg_rem  = rem_q;
        end
        bnd_beats = (13'd4096 - {1'b0, seg_addr[11:0]}) >> SIZE;
        len_calc  = 9'(MAX_BURST);
        if ({4'b0, len_calc} > bnd_beats) len_calc = bnd_beats[8:0];
        if (LEN_WIDTH'(len_calc) > seg_rem) len_calc = 9'(seg_rem);
    end

    assign in_data   = (state_q == S_DATA);
    assign RREADY    = tready & in_data;
    assign r_fire    = RVALID & RREADY;
    assign last_beat = (beat_q == len_q - 9'd1);

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        len_d     = len_q;
        beat_d    = beat_q;
        rem_d     = rem_q;
        arvalid_d = arvalid_q;
        error_d   = error_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                error_d = 1'b0;
                if (num_beats == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    load    = 1'b1;
                end
            end
            S_ADDR: if (ARREADY) begin
                arvalid_d = 1'b0;
                state_d   = S_DATA;
            end
            S_DATA: if (r_fire) begin
                if (RRESP != 2'b00 || RLAST != last_beat) error_d = 1'b1;
                if (last_beat) begin
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        load    = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + 9'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            araddr_d  = seg_addr;
            len_d     = len_calc;
            arlen_d   = 8'(len_calc - 9'd1);
            rem_d     = seg_rem - LEN_WIDTH'(len_calc);
            beat_d    = '0;
            arvalid_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            rem_q     <= '0;
            arvalid_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            rem_q     <= rem_d;
            arvalid_q <= arvalid_d;
            error_q   <= error_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign error    = error_q;
    assign ARADDR   = araddr_q;
    assign ARLEN    = arlen_q;
    assign ARSIZE   = 3'(SIZE);
    assign ARBURST  = 2'b01;
    assign ARCACHE  = 4'b0011;
    assign ARPROT   = 3'b000;
    assign ARLOCK   = 1'b0;
    assign ARQOS    = 4'b0000;
    assign ARREGION = 4'b0000;
    assign ARID     = ID_WIDTH'(ARID_VAL);
    assign ARVALID  = arvalid_q;
    assign tdata    = RDATA;
    assign tvalid   = RVALID & in_data;

    assign AWADDR   = '0;
    assign AWLEN    = '0;
    assign AWSIZE   = '0;
    assign AWBURST  = '0;
    assign AWID     = '0;
    assign AWVALID  = 1'b0;
    assign WDATA    = '0;
    assign WSTRB    = '0;
    assign WLAST    = 1'b0;
    assign WVALID   = 1'b0;
    assign BREADY   = 1'b1;

endmodule

// File: tb/tb_axi4_stream_reader.sv
// tb/tb_axi4_stream_reader.sv - scoreboard bench with AXI read slave model and stream sink
module tb_axi4_stream_reader;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] num_beats = '0;
    logic        busy, done, error;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE, ARPROT;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE, ARQOS, ARREGION, ARID;
    logic        ARLOCK, ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic [3:0]  RID;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWID, WSTRB;
    logic        AWVALID, WLAST, WVALID, BREADY;
    logic [31:0] tdata;
    logic        tvalid, tready;

    always #5 ACLK = ~ACLK;

    axi4_stream_reader dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .start_addr(start_addr),
        .num_beats(num_beats), .busy(busy), .done(done), .error(error),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARLOCK(ARLOCK), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWID(AWID), .AWVALID(AWVALID), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .BREADY(BREADY),
        .tdata(tdata), .tvalid(tvalid), .tready(tready)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } rbeat_t;

    rbeat_t      r_q[$];
    logic [31:0] exp_data_q[$];
    logic [39:0] exp_ar_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int ar_delay_cfg = 0, tready_rand = 0, err_beat = -1, early_burst = -1;
    int ar_wait = 0, slv_beat = 0, slv_burst = 0;
    int done_cnt = 0, busy_cnt = 0, arvalid_cnt = 0, beats_seen = 0;
    logic        stall_prev = 1'b0;
    logic [39:0] stall_ar = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #2;
    endtask

    // AXI read slave + stream sink; decides handshakes for the upcoming rising edge.
    initial begin
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RID = '0; RRESP = '0; RLAST = 1'b0;
        tready = 1'b0;
        forever begin
            @(negedge ACLK);
            ARREADY = ARVALID && (ar_wait >= ar_delay_cfg);
            RVALID  = (r_q.size() > 0);
            if (RVALID) begin
                RDATA = r_q[0].data; RLAST = r_q[0].last; RRESP = r_q[0].resp;
            end else begin
                RDATA = '0; RLAST = 1'b0; RRESP = '0;
            end
            tready = (tready_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall_prev && ARVALID) check("ar_stable", {ARADDR, ARLEN}, stall_ar);
            stall_prev = ARVALID && !ARREADY;
            stall_ar   = {ARADDR, ARLEN};
            if (ARVALID) arvalid_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (ARVALID && ARREADY) begin
                ar_wait = 0;
                if (exp_ar_q.size() == 0) begin
                    check("ar_unexpected", 1, 0);
                end else begin
                    check("ar_addr_len", {ARADDR, ARLEN}, exp_ar_q.pop_front());
                end
                check("ar_fixed", {ARSIZE, ARBURST, ARCACHE, ARPROT, ARLOCK, ARQOS, ARREGION, ARID},
                      {3'd2, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0});
                for (int i = 0; i <= int'(ARLEN); i++) begin
                    rbeat_t b;
                    b.data = mem_word(ARADDR + 32'(i * 4));
                    if (slv_burst == early_burst && ARLEN > 0) b.last = (i == int'(ARLEN) - 1);
                    else b.last = (i == int'(ARLEN));
                    b.resp = (slv_beat == err_beat) ? 2'b10 : 2'b00;
                    slv_beat++;
                    r_q.push_back(b);
                end
                slv_burst++;
            end else if (ARVALID) begin
                ar_wait++;
            end
            if (RVALID && RREADY) void'(r_q.pop_front());
            if (tvalid && tready) begin
                beats_seen++;
                if (exp_data_q.size() == 0) check("beat_extra", 1, 0);
                else check("beat_data", tdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic expect_xfer(input logic [31:0] addr, input int n);
        logic [31:0] a;
        int rem, len, bnd;
        a = addr & ~32'h3;
        rem = n;
        while (rem > 0) begin
            bnd = (4096 - int'(a[11:0])) / 4;
            len = rem;
            if (len > 16) len = 16;
            if (len > bnd) len = bnd;
            exp_ar_q.push_back({a, 8'(len - 1)});
            for (int i = 0; i < len; i++) exp_data_q.push_back(mem_word(a + 32'(i * 4)));
            a = a + 32'(len * 4);
            rem = rem - len;
        end
        slv_beat = 0; slv_burst = 0; done_cnt = 0; busy_cnt = 0; arvalid_cnt = 0; beats_seen = 0;
    endtask

    task automatic pulse_start(input logic [31:0] addr, input int n);
        tick();
        start = 1'b1; start_addr = addr; num_beats = 16'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int n, input int ard, input int trand,
                            input int eb, input int ebu, input logic exp_err);
        ar_delay_cfg = ard; tready_rand = trand; err_beat = eb; early_burst = ebu;
        expect_xfer(addr, n);
        pulse_start(addr, n);
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
        check("done_seen", done_cnt > 0, 1);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("busy_idle", busy, 0);
        check("beats_left", exp_data_q.size(), 0);
        check("ar_left", exp_ar_q.size(), 0);
        check("beat_count", beats_seen, n);
        check("error_final", error, exp_err);
        if (n == 0) begin
            check("zero_busy_cycles", busy_cnt, 1);
            check("zero_no_arvalid", arvalid_cnt, 0);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_ar", {ARADDR, ARLEN}, 40'd0);
        ARESET = 1'b0;
        tick();

        run_xfer(32'h0000_1000, 40, 0, 0, -1, -1, 1'b0);
        run_xfer(32'h0000_0FF0, 8, 0, 0, -1, -1, 1'b0);
        run_xfer(32'h0000_0100, 0, 0, 0, -1, -1, 1'b0);
        run_xfer(32'h0000_3F80, 33, 5, 1, -1, -1, 1'b0);
        run_xfer(32'h0000_2000, 40, 0, 1, 3, 1, 1'b1);
        repeat (4) tick();
        check("error_sticky", error, 1);
        run_xfer(32'h0000_1006, 4, 2, 0, -1, -1, 1'b0);

        ar_delay_cfg = 0; tready_rand = 0; err_beat = -1; early_burst = -1;
        expect_xfer(32'h0000_5000, 40);
        pulse_start(32'h0000_5000, 40);
        for (int c = 0; c < 500 && beats_seen < 5; c++) tick();
        check("reset_reached_data", beats_seen >= 5, 1);
        ARESET = 1'b1;
        #1;
        check("mid_rst_arvalid", ARVALID, 0);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_busy", busy, 0);
        r_q.delete(); exp_data_q.delete(); exp_ar_q.delete();
        stall_prev = 1'b0; ar_wait = 0;
        repeat (2) tick();
        ARESET = 1'b0;
        tick();
        run_xfer(32'h0000_1000, 20, 1, 1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
